// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_OUT   = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  localparam logic [1:0]  RESP_OKAY          = 2'b00;
  // addi x0,x0,0 -- a harmless word handed to the core on any fault
  localparam logic [31:0] FAULT_INST_DEFAULT = 32'h0000_0013;

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch: one AR/R read per accepted PC, result returned to the core with PC and fault flag.
// Latency: accept -> inst_valid in 3 cycles with zero-wait memory; misaligned PCs fault in 1 cycle.
// Backpressure: result held while inst_ready is low; a new fetch is taken only as the held one retires.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter int          ADDR_W     = 32,
  parameter logic [31:0] FAULT_INST = FAULT_INST_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_valid,
  input  logic [ADDR_W-1:0] fetch_pc,
  output logic              fetch_ready,
  input  logic              flush,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_fault,
  output logic              inst_valid,
  input  logic              inst_ready
);

  state_t            state;
  logic [ADDR_W-1:0] pc_q;
  logic              flush_pend;
  logic              accept;
  logic              aligned;

  assign fetch_ready = rst & ((state == S_IDLE) |
                              ((state == S_OUT) & inst_ready & ~flush));
  assign accept      = fetch_valid & fetch_ready;
  assign aligned     = (fetch_pc[1:0] == 2'b00);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      arvalid    <= 1'b0;
      araddr     <= '0;
      rready     <= 1'b0;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
      inst_fault <= 1'b0;
      pc_q       <= '0;
      flush_pend <= 1'b0;
    end else begin
      case (state)
        S_ADDR: begin
          // The address phase always completes; a flush only turns the data phase into a drain.
          if (arready) begin
            arvalid    <= 1'b0;
            rready     <= 1'b1;
            flush_pend <= 1'b0;
            state      <= (flush_pend | flush) ? S_DRAIN : S_DATA;
          end else if (flush) begin
            flush_pend <= 1'b1;
          end
        end
        S_DATA: begin
          if (rvalid) begin
            rready <= 1'b0;
            if (flush) begin
              state <= S_IDLE;
            end else begin
              inst_valid <= 1'b1;
              inst_pc    <= pc_q;
              if (rresp == RESP_OKAY) begin
                inst       <= rdata;
                inst_fault <= 1'b0;
              end else begin
                inst       <= FAULT_INST;
                inst_fault <= 1'b1;
              end
              state <= S_OUT;
            end
          end else if (flush) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (rvalid) begin
            rready <= 1'b0;
            state  <= S_IDLE;
          end
        end
        S_OUT: begin
          if (flush | inst_ready) begin
            inst_valid <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: begin
        end
      endcase

      // A new fetch overrides the retire path above when taken back-to-back from OUT.
      if (accept) begin
        if (aligned) begin
          araddr  <= fetch_pc;
          pc_q    <= fetch_pc;
          arvalid <= 1'b1;
          state   <= S_ADDR;
        end else begin
          inst       <= FAULT_INST;
          inst_fault <= 1'b1;
          inst_pc    <= fetch_pc;
          inst_valid <= 1'b1;
          state      <= S_OUT;
        end
      end
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: vector table, directed corner sequences and a randomized run against a transaction-level model.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_valid, fetch_ready, flush;
  logic [31:0] fetch_pc, araddr, rdata, inst, inst_pc;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  rresp;
  logic        inst_fault, inst_valid, inst_ready;

  int total = 0;
  int bad   = 0;

  ifu_fetch #(.ADDR_W(32), .FAULT_INST(32'h0000_0013)) dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_ready(fetch_ready),
    .flush(flush),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .inst(inst), .inst_pc(inst_pc), .inst_fault(inst_fault),
    .inst_valid(inst_valid), .inst_ready(inst_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    int          ar_dly;
    int          r_dly;
    logic [31:0] exp_inst;
    logic        exp_fault;
    int          exp_lat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fetch_valid = 1'b0; fetch_pc = '0; flush = 1'b0; arready = 1'b0;
    rvalid = 1'b0; rdata = '0; rresp = 2'b00; inst_ready = 1'b0;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return (a[5:2] == 4'd7);
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int lat, arc, rc;
    bit ar_seen;
    fetch_valid = 1'b1; fetch_pc = v.pc; inst_ready = 1'b0;
    #1 chk1($sformatf("v%0d_fetch_ready", idx), fetch_ready, 1'b1);
    tick();
    fetch_valid = 1'b0;
    lat = 1; arc = 0; rc = 0; ar_seen = 0;
    while (!inst_valid && lat < 60) begin
      arready = 1'b0; rvalid = 1'b0;
      if (arvalid) begin
        if (!ar_seen) chk($sformatf("v%0d_araddr", idx), araddr, v.pc);
        ar_seen = 1;
        arready = (arc == v.ar_dly);
        arc++;
      end
      if (rready) begin
        rvalid = (rc == v.r_dly); rdata = v.rdata; rresp = v.rresp;
        rc++;
      end
      tick();
      lat++;
    end
    arready = 1'b0; rvalid = 1'b0;
    chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
    chk($sformatf("v%0d_inst", idx), inst, v.exp_inst);
    chk($sformatf("v%0d_inst_pc", idx), inst_pc, v.pc);
    chk1($sformatf("v%0d_inst_fault", idx), inst_fault, v.exp_fault);
    chk1($sformatf("v%0d_bus_used", idx), ar_seen, v.pc[1:0] == 2'b00);
    inst_ready = 1'b1;
    #1 chk1($sformatf("v%0d_ready_on_consume", idx), fetch_ready, 1'b1);
    tick();
    inst_ready = 1'b0;
    chk1($sformatf("v%0d_valid_cleared", idx), inst_valid, 1'b0);
  endtask

  task automatic fetch_to_data(input logic [31:0] pc);
    fetch_valid = 1'b1; fetch_pc = pc;
    tick();
    fetch_valid = 1'b0; arready = 1'b1;
    tick();
    arready = 1'b0;
  endtask

  task automatic fetch_to_out(input logic [31:0] pc, input logic [31:0] d);
    fetch_to_data(pc);
    rvalid = 1'b1; rdata = d; rresp = 2'b00;
    tick();
    rvalid = 1'b0;
  endtask

  task automatic random_phase(input int ncyc);
    logic [31:0] it_pc, it_inst, tmp;
    bit it_valid, it_killed, it_done, it_aligned, it_fault;
    bit mem_busy, cons, acc, arh, rh;
    logic [31:0] mem_addr;
    int mem_dly, idle_cnt, delivered;
    it_valid = 0; it_killed = 0; it_done = 0; it_aligned = 0; it_fault = 0;
    it_pc = '0; it_inst = '0; mem_busy = 0; mem_addr = '0; mem_dly = 0;
    idle_cnt = 0; delivered = 0;
    for (int c = 0; c < ncyc; c++) begin
      tmp = 32'h8000_0000 | (32'($urandom_range(0, 63)) << 2);
      if ($urandom_range(0, 9) == 0) tmp[1:0] = 2'($urandom_range(1, 3));
      fetch_valid = ($urandom_range(0, 3) != 0);
      fetch_pc    = tmp;
      flush       = ($urandom_range(0, 11) == 0);
      inst_ready  = ($urandom_range(0, 2) != 0);
      arready     = 1'($urandom_range(0, 1));
      if (mem_busy && mem_dly == 0) begin
        rvalid = 1'b1; rdata = mem_word(mem_addr);
        rresp = mem_err(mem_addr) ? 2'b10 : 2'b00;
      end else begin
        rvalid = 1'b0; rdata = $urandom; rresp = 2'b00;
      end
      @(negedge clk);
      if (inst_valid && !(it_valid && !it_killed && !it_done)) begin
        chk1("rnd_spurious_inst_valid", inst_valid, 1'b0);
      end
      if (arvalid && !(it_valid && it_aligned)) begin
        chk1("rnd_spurious_arvalid", arvalid, 1'b0);
      end
      cons = inst_valid & inst_ready & ~flush;
      acc  = fetch_valid & fetch_ready;
      arh  = arvalid & arready;
      rh   = rvalid & rready;
      if (cons) begin
        chk("rnd_inst", inst, it_inst);
        chk("rnd_inst_pc", inst_pc, it_pc);
        chk1("rnd_inst_fault", inst_fault, it_fault);
        it_done = 1;
        delivered++;
      end
      if (flush && it_valid && !it_done) it_killed = 1;
      if (arh) begin
        chk("rnd_araddr", araddr, it_pc);
        mem_busy = 1; mem_addr = araddr; mem_dly = $urandom_range(0, 2);
      end else if (rh) begin
        mem_busy = 0;
      end else if (mem_busy && mem_dly > 0) begin
        mem_dly--;
      end
      if (acc) begin
        if (it_valid && !it_done && !it_killed) chk1("rnd_accept_while_busy", acc, 1'b0);
        it_valid = 1; it_killed = 0; it_done = 0;
        it_pc = fetch_pc; it_aligned = (fetch_pc[1:0] == 2'b00);
        if (!it_aligned || mem_err(fetch_pc)) begin
          it_inst = 32'h0000_0013; it_fault = 1;
        end else begin
          it_inst = mem_word(fetch_pc); it_fault = 0;
        end
      end
      if (cons || acc) idle_cnt = 0;
      else idle_cnt++;
      if (idle_cnt > 200) begin
        chk1("rnd_stall_timeout", 1'b1, 1'b0);
        break;
      end
      @(posedge clk);
      #1;
    end
    idle_inputs();
    chk1("rnd_progress", delivered >= 20, 1'b1);
  endtask

  initial begin
    vecs[0] = '{32'h8000_0000, 32'h0010_0073, 2'b00, 0, 0, 32'h0010_0073, 1'b0, 3};
    vecs[1] = '{32'h8000_0004, 32'h1234_5678, 2'b00, 2, 1, 32'h1234_5678, 1'b0, 6};
    vecs[2] = '{32'h8000_0002, 32'hFFFF_FFFF, 2'b00, 0, 0, 32'h0000_0013, 1'b1, 1};
    vecs[3] = '{32'h8000_0008, 32'hCAFE_F00D, 2'b10, 0, 0, 32'h0000_0013, 1'b1, 3};
    vecs[4] = '{32'h8000_0001, 32'h0000_0000, 2'b00, 0, 0, 32'h0000_0013, 1'b1, 1};
    vecs[5] = '{32'h8000_000C, 32'h0BAD_C0DE, 2'b11, 1, 3, 32'h0000_0013, 1'b1, 7};
    vecs[6] = '{32'h0000_0FFC, 32'hFFFF_FFFF, 2'b00, 0, 2, 32'hFFFF_FFFF, 1'b0, 5};
    vecs[7] = '{32'h8000_0003, 32'h0000_0000, 2'b00, 0, 0, 32'h0000_0013, 1'b1, 1};

    idle_inputs();
    fetch_valid = 1'b1;
    #12;
    chk1("rst_arvalid", arvalid, 1'b0);
    chk1("rst_rready", rready, 1'b0);
    chk1("rst_inst_valid", inst_valid, 1'b0);
    chk1("rst_inst_fault", inst_fault, 1'b0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_araddr", araddr, 32'h0);
    chk1("rst_fetch_ready", fetch_ready, 1'b0);
    fetch_valid = 1'b0;
    @(negedge clk) rst = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Backpressure, then back-to-back fetch on the retire cycle
    fetch_to_out(32'h8000_0040, 32'h1111_2222);
    for (int k = 0; k < 5; k++) begin
      inst_ready = 1'b0; fetch_valid = 1'b1; fetch_pc = 32'h8000_0004;
      #1;
      chk1("bp_fetch_ready", fetch_ready, 1'b0);
      chk("bp_inst", inst, 32'h1111_2222);
      chk("bp_inst_pc", inst_pc, 32'h8000_0040);
      tick();
    end
    inst_ready = 1'b1;
    #1 chk1("bp_release_ready", fetch_ready, 1'b1);
    tick();
    fetch_valid = 1'b0; inst_ready = 1'b0;
    chk1("bp_next_arvalid", arvalid, 1'b1);
    chk("bp_next_araddr", araddr, 32'h8000_0004);
    chk1("bp_old_dropped", inst_valid, 1'b0);
    arready = 1'b1; tick(); arready = 1'b0;
    rvalid = 1'b1; rdata = 32'h3333_4444; tick(); rvalid = 1'b0;
    chk("bp_next_inst", inst, 32'h3333_4444);
    inst_ready = 1'b1; tick(); inst_ready = 1'b0;

    // Flush during a stalled address phase
    fetch_valid = 1'b1; fetch_pc = 32'h8000_0010;
    tick();
    fetch_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      flush = (k == 2);
      #1;
      chk1("fa_arvalid_held", arvalid, 1'b1);
      chk("fa_araddr_held", araddr, 32'h8000_0010);
      tick();
    end
    flush = 1'b0; arready = 1'b1;
    tick();
    arready = 1'b0;
    chk1("fa_arvalid_dropped", arvalid, 1'b0);
    chk1("fa_drain_rready", rready, 1'b1);
    tick();
    chk1("fa_drain_wait", inst_valid, 1'b0);
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    tick();
    rvalid = 1'b0;
    chk1("fa_no_inst", inst_valid, 1'b0);
    chk1("fa_idle_ready", fetch_ready, 1'b1);
    tick();
    chk1("fa_no_inst_later", inst_valid, 1'b0);

    // Flush while holding a result
    fetch_to_out(32'h8000_0020, 32'h0000_1111);
    chk1("fo_valid", inst_valid, 1'b1);
    flush = 1'b1; inst_ready = 1'b1;
    #1 chk1("fo_ready_blocked", fetch_ready, 1'b0);
    tick();
    flush = 1'b0; inst_ready = 1'b0;
    chk1("fo_dropped", inst_valid, 1'b0);
    chk1("fo_idle_ready", fetch_ready, 1'b1);

    // Flush in the same cycle as the read beat
    fetch_to_data(32'h8000_0024);
    rvalid = 1'b1; rdata = 32'h5555_AAAA; flush = 1'b1;
    tick();
    rvalid = 1'b0; flush = 1'b0;
    chk1("fr_no_inst", inst_valid, 1'b0);
    chk1("fr_rready_low", rready, 1'b0);
    chk1("fr_idle_ready", fetch_ready, 1'b1);
    tick();
    chk1("fr_no_inst_later", inst_valid, 1'b0);

    // Flush in the data phase before the beat arrives
    fetch_to_data(32'h8000_0028);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk1("fd_drain_rready", rready, 1'b1);
    chk1("fd_not_idle", fetch_ready, 1'b0);
    rvalid = 1'b1; rdata = 32'h7777_8888;
    tick();
    rvalid = 1'b0;
    chk1("fd_no_inst", inst_valid, 1'b0);
    chk1("fd_idle_ready", fetch_ready, 1'b1);

    // Asynchronous reset in the data phase and while holding a result
    fetch_to_data(32'h8000_0030);
    #2 rst = 1'b0;
    #1;
    chk1("ar_arvalid", arvalid, 1'b0);
    chk1("ar_rready", rready, 1'b0);
    chk1("ar_inst_valid", inst_valid, 1'b0);
    chk1("ar_fetch_ready", fetch_ready, 1'b0);
    @(negedge clk) rst = 1'b1;
    tick();
    fetch_to_out(32'h8000_0034, 32'h9999_0000);
    #2 rst = 1'b0;
    #1 chk1("ar_out_inst_valid", inst_valid, 1'b0);
    @(negedge clk) rst = 1'b1;
    tick();
    run_vec(vecs[0], 8);

    random_phase(3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch stage that sits directly upstream of the single-cycle core.
- Accepts a fetch PC from the core and issues an AXI4-Lite-style read (AR/R channels) to instruction memory.
- Returns the 32-bit instruction to the core over a valid/ready handshake, together with its PC and a fault flag.
- Supports flush/redirect, drops stale responses, and faults misaligned PCs without touching the bus.

Parameters:
- ADDR_W, 32, fetch address width and bus address width.
- FAULT_INST, 32'h0000_0013, instruction word delivered on any fault (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low (asserted when 0).
- fetch_valid  in  1  core presents fetch_pc.
- fetch_pc  in  ADDR_W  address to fetch.
- fetch_ready  out  1  fetch accepted when fetch_valid & fetch_ready.
- flush  in  1  kill in-flight or held fetch.
- araddr  out  ADDR_W  read address.
- arvalid  out  1  read address valid.
- arready  in  1  memory accepts address.
- rdata  in  32  read data.
- rresp  in  2  read response; 2'b00 = OKAY, anything else = error.
- rvalid  in  1  read data valid.
- rready  out  1  IFU accepts read data.
- inst  out  32  instruction to core.
- inst_pc  out  ADDR_W  PC of inst.
- inst_fault  out  1  inst is FAULT_INST due to misalignment or bus error.
- inst_valid  out  1  inst/inst_pc/inst_fault valid.
- inst_ready  in  1  core consumes instruction.

Behaviour:
- States: IDLE, ADDR (arvalid=1), DATA (rready=1), OUT (inst_valid=1), DRAIN (rready=1, response discarded).
- Reset values, all asynchronous on rst=0:
  - state=IDLE; arvalid=0; rready=0; inst_valid=0; inst=0; inst_pc=0; inst_fault=0; araddr=0.
  - fetch_ready is forced 0 while rst=0.
- fetch_ready is combinational: (state==IDLE) | (state==OUT & inst_ready & ~flush).
- Fetch accept:
  - Aligned pc (fetch_pc[1:0]==0): araddr<=fetch_pc, record pc, next state ADDR.
  - Misaligned pc: no bus request; next state OUT with inst=FAULT_INST, inst_fault=1, inst_pc=fetch_pc.
- ADDR:
  - arvalid held high and araddr held stable until arready; arvalid is never dropped early.
  - On arready: no flush pending -> DATA; flush pending -> DRAIN.
- DATA:
  - On rvalid & rready: rresp==OKAY -> inst=rdata, inst_fault=0; otherwise inst=FAULT_INST, inst_fault=1. Next state OUT.
  - flush with no rvalid -> DRAIN.
  - flush in the same cycle as rvalid -> beat consumed and discarded, next state IDLE.
- DRAIN: wait for one rvalid beat, discard it, go to IDLE. flush has no further effect.
- OUT:
  - inst, inst_pc, inst_fault held stable while inst_valid & ~inst_ready.
  - inst_ready & ~flush: consumed; if a new fetch is accepted the same cycle, go to ADDR (or OUT on misalign), else IDLE.
  - flush: inst_valid=0 next cycle, state IDLE, held instruction dropped.
- Flush pending flag:
  - Set by flush while in ADDR; cleared on leaving ADDR.
  - Multiple flushes before arready collapse into one pending flush.
- flush in IDLE: no effect; a fetch presented the same cycle is accepted.
- Latency, zero-wait memory: accept at cycle N -> arvalid N+1; arready at N+1, rvalid at N+2 -> inst_valid at N+3.
  - Steady-state throughput is one instruction per 3 cycles.
- Only one outstanding read at any time; a response never arrives in IDLE or OUT. rvalid in those states is a protocol error and is ignored.
- Asynchronous reset mid-transaction returns to IDLE immediately. No drain is performed; the memory must also be reset.

Decomposition:
- Shared package ifu_pkg holds:
  - state enum (IDLE, ADDR, DATA, OUT, DRAIN);
  - RESP_OKAY = 2'b00;
  - default FAULT_INST constant.
- Single module; the FSM plus output registers are small enough that no sub-module is warranted.

Test Plan:
- Basic fetch: fetch_pc=0x8000_0000, arready/rvalid zero-wait, rdata=0x0010_0073 -> araddr=0x8000_0000, inst=0x0010_0073, inst_pc=0x8000_0000, inst_fault=0, inst_valid first seen 3 cycles after accept.
- Backpressure: inst_ready=0 for 5 cycles -> inst/inst_pc stable and fetch_ready=0 throughout; inst_ready=1 with next fetch 0x8000_0004 in the same cycle -> arvalid next cycle, araddr=0x8000_0004.
- Misaligned and bus error:
  - fetch_pc=0x8000_0002 -> no arvalid; inst=0x0000_0013, inst_fault=1 the next cycle.
  - rresp=2'b10 on an aligned fetch -> inst=0x0000_0013, inst_fault=1.
- Flush in ADDR: arready delayed 4 cycles, flush pulsed in cycle 2 -> arvalid stays high until arready; rdata=0xDEAD_BEEF then discarded with inst_valid never set; fetch_ready=1 in the cycle after the beat.
- Flush in OUT and same-cycle flush+rvalid: inst_valid drops the next cycle and the returned word is never delivered; state is IDLE, verified by fetch_ready=1.
- Reset: rst driven 0 asynchronously while in DATA -> arvalid, rready, inst_valid go 0 without a clock edge; after rst=1, fetch 0x8000_0000 completes normally.
